// File: rtl/pipe_ctrl_fsm.sv
// rtl/pipe_ctrl_fsm.sv - pipeline stall/flush/redirect control FSM with trap, mret and wfi sleep handling
// Optional perf counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl_fsm #(
  parameter int DATA_WIDTH = 32,
  parameter int WAKE_DELAY = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  id_valid_i,
  input  logic                  id_illegal_i,
  input  logic                  id_ecall_i,
  input  logic                  id_ebrk_i,
  input  logic                  id_mret_i,
  input  logic                  id_wfi_i,
  input  logic [4:0]            id_rs1_i,
  input  logic [4:0]            id_rs2_i,
  input  logic [DATA_WIDTH-1:0] id_pc_i,
  input  logic                  ex_mem_rd_en_i,
  input  logic [4:0]            ex_rd_i,
  input  logic                  ex_pc_sel_i,
  input  logic                  mem_busy_i,
  input  logic                  irq_pending_i,
  input  logic [DATA_WIDTH-1:0] csr_mtvec_i,
  input  logic [DATA_WIDTH-1:0] csr_mepc_i,
  output logic                  stall_if_o,
  output logic                  stall_id_o,
  output logic                  stall_ex_o,
  output logic                  flush_id_o,
  output logic                  flush_ex_o,
  output logic                  pc_set_o,
  output logic [DATA_WIDTH-1:0] pc_target_o,
  output logic                  csr_save_o,
  output logic                  csr_restore_o,
  output logic [DATA_WIDTH-1:0] csr_mepc_o,
  output logic [4:0]            csr_cause_o,
  output logic                  sleep_o,
  output logic [2:0]            state_o,
  output logic [31:0]           perf_stall_cnt_o,
  output logic [31:0]           perf_flush_cnt_o
);

  typedef enum logic [2:0] {
    RUN   = 3'd0,
    TRAP  = 3'd1,
    MRET  = 3'd2,
    SLEEP = 3'd3,
    WAKE  = 3'd4
  } state_t;

  localparam logic [3:0] WAKE_LOAD = 4'(WAKE_DELAY);

  state_t                state_q, state_nxt;
  logic [DATA_WIDTH-1:0] epc_q, epc_nxt;
  logic [4:0]            cause_q, cause_nxt;
  logic [3:0]            wake_cnt_q, wake_cnt_nxt;
  logic                  load_use;
  logic                  id_trap;
  logic                  perf_flush_evt;

  assign load_use = ex_mem_rd_en_i && (ex_rd_i != 5'd0) &&
                    ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));
  assign id_trap  = id_valid_i && (id_illegal_i || id_ebrk_i || id_ecall_i);

  always_comb begin
    state_nxt      = state_q;
    epc_nxt        = epc_q;
    cause_nxt      = cause_q;
    wake_cnt_nxt   = wake_cnt_q;
    stall_if_o     = 1'b0;
    stall_id_o     = 1'b0;
    stall_ex_o     = 1'b0;
    flush_id_o     = 1'b0;
    flush_ex_o     = 1'b0;
    pc_set_o       = 1'b0;
    pc_target_o    = '0;
    csr_save_o     = 1'b0;
    csr_restore_o  = 1'b0;
    csr_mepc_o     = '0;
    csr_cause_o    = 5'd0;
    sleep_o        = 1'b0;
    perf_flush_evt = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_busy_i) begin
          stall_if_o = 1'b1;
          stall_id_o = 1'b1;
          stall_ex_o = 1'b1;
        end else if (ex_pc_sel_i) begin
          // ID holds a wrong-path instruction, so its system flags are dropped
          flush_id_o     = 1'b1;
          flush_ex_o     = 1'b1;
          perf_flush_evt = 1'b1;
        end else if (id_trap) begin
          stall_if_o = 1'b1;
          flush_ex_o = 1'b1;
          epc_nxt    = id_pc_i;
          cause_nxt  = id_illegal_i ? 5'd2 : (id_ebrk_i ? 5'd3 : 5'd11);
          state_nxt  = TRAP;
        end else if (id_valid_i && id_mret_i) begin
          stall_if_o = 1'b1;
          flush_ex_o = 1'b1;
          state_nxt  = MRET;
        end else if (id_valid_i && id_wfi_i) begin
          if (!irq_pending_i) begin
            stall_if_o = 1'b1;
            stall_id_o = 1'b1;
            flush_ex_o = 1'b1;
            state_nxt  = SLEEP;
          end
        end else if (load_use) begin
          stall_if_o = 1'b1;
          stall_id_o = 1'b1;
          flush_ex_o = 1'b1;
        end
      end
      TRAP: begin
        pc_set_o       = 1'b1;
        pc_target_o    = {csr_mtvec_i[DATA_WIDTH-1:2], 2'b00};
        csr_save_o     = 1'b1;
        csr_mepc_o     = epc_q;
        csr_cause_o    = cause_q;
        flush_id_o     = 1'b1;
        flush_ex_o     = 1'b1;
        perf_flush_evt = 1'b1;
        state_nxt      = RUN;
      end
      MRET: begin
        pc_set_o       = 1'b1;
        pc_target_o    = csr_mepc_i;
        csr_restore_o  = 1'b1;
        flush_id_o     = 1'b1;
        flush_ex_o     = 1'b1;
        perf_flush_evt = 1'b1;
        state_nxt      = RUN;
      end
      SLEEP: begin
        sleep_o    = 1'b1;
        stall_if_o = 1'b1;
        stall_id_o = 1'b1;
        flush_ex_o = 1'b1;
        if (irq_pending_i) begin
          wake_cnt_nxt = WAKE_LOAD;
          state_nxt    = WAKE;
        end
      end
      WAKE: begin
        stall_if_o = 1'b1;
        stall_id_o = 1'b1;
        flush_ex_o = 1'b1;
        // WAKE lasts exactly WAKE_DELAY cycles; counter reaches 0 on the exit edge
        if (wake_cnt_q <= 4'd1) begin
          wake_cnt_nxt = 4'd0;
          state_nxt    = RUN;
        end else begin
          wake_cnt_nxt = wake_cnt_q - 4'd1;
        end
      end
      default: state_nxt = RUN;
    endcase

    // Outputs are combinational on inputs in RUN, so force them quiet while reset is held
    if (rst_i) begin
      stall_if_o     = 1'b0;
      stall_id_o     = 1'b0;
      stall_ex_o     = 1'b0;
      flush_id_o     = 1'b0;
      flush_ex_o     = 1'b0;
      pc_set_o       = 1'b0;
      pc_target_o    = '0;
      csr_save_o     = 1'b0;
      csr_restore_o  = 1'b0;
      csr_mepc_o     = '0;
      csr_cause_o    = 5'd0;
      sleep_o        = 1'b0;
      perf_flush_evt = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      epc_q      <= '0;
      cause_q    <= 5'd0;
      wake_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_nxt;
      epc_q      <= epc_nxt;
      cause_q    <= cause_nxt;
      wake_cnt_q <= wake_cnt_nxt;
    end
  end

  assign state_o = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 32'd0;
    end else begin
      if (stall_if_o)     perf_stall_q <= perf_stall_q + 32'd1;
      if (perf_flush_evt) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_stall_cnt_o = perf_stall_q;
  assign perf_flush_cnt_o = perf_flush_q;
`else
  logic unused_perf;
  assign unused_perf      = perf_flush_evt;
  assign perf_stall_cnt_o = 32'd0;
  assign perf_flush_cnt_o = 32'd0;
`endif

endmodule
